// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forwarding-source codes and the register-match helper used by forwarding.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    function automatic logic reg_hit(input logic werf, input logic [4:0] rd,
                                     input logic [4:0] rs);
        return werf && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd.sv
// EX-operand forwarding selection; the MEM stage is younger than WB and so
// holds the more recent value when both match.
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_ex_rs1,
    input  logic [4:0] i_ex_rs2,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_werf,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_werf,
    output logic [1:0] o_fwd_a_sel,
    output logic [1:0] o_fwd_b_sel
);

    always_comb begin
        o_fwd_a_sel = FWD_RF;
        o_fwd_b_sel = FWD_RF;
        if (reg_hit(i_mem_werf, i_mem_rd, i_ex_rs1))
            o_fwd_a_sel = FWD_MEM;
        else if (reg_hit(i_wb_werf, i_wb_rd, i_ex_rs1))
            o_fwd_a_sel = FWD_WB;
        if (reg_hit(i_mem_werf, i_mem_rd, i_ex_rs2))
            o_fwd_b_sel = FWD_MEM;
        else if (reg_hit(i_wb_werf, i_wb_rd, i_ex_rs2))
            o_fwd_b_sel = FWD_WB;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait FSM with timeout fault,
// branch/load-use stage control, forwarding selects and a stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_rd,
    input  logic        mem_werf,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic [4:0]  wb_rd,
    input  logic        wb_werf,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_e         r_state;
    state_e         w_next_state;
    logic [CW-1:0]  r_wait_cnt;
    logic [31:0]    r_stall_cycles;
    logic           w_mem_stall;
    logic           w_load_use;
    logic           w_wait_last;
    logic [1:0]     w_fwd_a;
    logic [1:0]     w_fwd_b;

    assign w_mem_stall = (r_state != ST_FAULT) && mem_req && !mem_ready;
    assign w_load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                         ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign w_wait_last = (r_wait_cnt == CW'(MAX_WAIT - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:      if (mem_req && !mem_ready) w_next_state = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (mem_ready)        w_next_state = ST_RUN;
                else if (w_wait_last) w_next_state = ST_FAULT;
            end
            ST_FAULT:    w_next_state = ST_FAULT;
            default:     w_next_state = ST_RUN;
        endcase
    end

    // Counter sits at zero throughout RUN, which clears it on MEM_WAIT entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RUN)
                r_wait_cnt <= '0;
            else if (r_state == ST_MEM_WAIT && !mem_ready)
                r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // Stage control is purely combinational; reset forces everything idle.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst && r_state != ST_FAULT) begin
            if (w_mem_stall) begin
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cycles <= '0;
        else if (!pc_en && r_state != ST_FAULT && r_stall_cycles != 32'hFFFF_FFFF)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    fwd_unit u_fwd (
        .i_ex_rs1    (ex_rs1),
        .i_ex_rs2    (ex_rs2),
        .i_mem_rd    (mem_rd),
        .i_mem_werf  (mem_werf),
        .i_wb_rd     (wb_rd),
        .i_wb_werf   (wb_werf),
        .o_fwd_a_sel (w_fwd_a),
        .o_fwd_b_sel (w_fwd_b)
    );

    assign fwd_a_sel    = rst ? w_fwd_a : FWD_RF;
    assign fwd_b_sel    = rst ? w_fwd_b : FWD_RF;
    assign mem_err      = rst && (r_state == ST_FAULT);
    assign stall_cycles = r_stall_cycles;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios followed by randomized
// traffic, all checked against a behavioural model of the control rules.
module tb_pipeline_ctrl;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_mem_read, ex_branch_taken, mem_werf, mem_req, mem_ready, wb_werf;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel, dbg_state;
    logic        mem_err;
    logic [31:0] stall_cycles;

    int          n_checks = 0;
    int          n_fail   = 0;

    // model: faulted flag, consecutive not-ready cycles of current access, stall total
    bit          m_fault;
    int          m_lows;
    logic [31:0] m_stalls;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_werf(mem_werf), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_werf(wb_werf),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctrl_vec();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (mem_werf && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
        if (wb_werf && wb_rd != 5'd0 && wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    // Expected stage control {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}.
    function automatic logic [8:0] ctrl_ref();
        logic lu;
        lu = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (!rst || m_fault)         return 9'b00000_0000;
        if (mem_req && !mem_ready)   return 9'b00001_0001;
        if (ex_branch_taken)         return 9'b11111_1100;
        if (lu)                      return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    task automatic model_reset();
        m_fault  = 1'b0;
        m_lows   = 0;
        m_stalls = 32'd0;
    endtask

    // One clock cycle: check combinational outputs mid-cycle, then advance the model.
    task automatic step();
        logic [8:0] e_ctrl;
        @(negedge clk);
        e_ctrl = ctrl_ref();
        chk("ctrl", 32'(ctrl_vec()), 32'(e_ctrl));
        chk("fwd_a_sel", 32'(fwd_a_sel), rst ? 32'(fwd_ref(ex_rs1)) : 32'd0);
        chk("fwd_b_sel", 32'(fwd_b_sel), rst ? 32'(fwd_ref(ex_rs2)) : 32'd0);
        chk("mem_err", 32'(mem_err), 32'(rst && m_fault));
        chk("stall_cycles", stall_cycles, m_stalls);
        @(posedge clk);
        if (rst && !m_fault) begin
            if (!e_ctrl[8] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (mem_req && !mem_ready) begin
                m_lows++;
                // request start cycle plus MAX_WAIT waiting cycles, all not ready
                if (m_lows == MAXW + 1) m_fault = 1'b1;
            end else begin
                m_lows = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        mem_rd = 5'd0; wb_rd = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_werf = 1'b0; wb_werf = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // Asynchronous reset applied between edges; outputs must go idle at once.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_ctrl", 32'(ctrl_vec()), 32'd0);
        chk("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        step();
        step();
        chk("reset_stall_cycles", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // load x5 in EX, consumer in ID
        ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs2 = 5'd5;
        step();
        chk("loaduse_stall_count", stall_cycles, 32'd1);
        // same hazard with a taken branch: no stall
        ex_branch_taken = 1'b1;
        step();
        chk("branch_no_stall", stall_cycles, 32'd1);
        idle_inputs();
        step();

        // memory wait: three not-ready cycles then ready
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        step(); step(); step();
        mem_ready = 1'b1;
        step();
        mem_req = 1'b0;
        chk("memwait_stall_count", stall_cycles, 32'd3);
        chk("memwait_release_pc_en", 32'(pc_en), 32'd1);
        step();

        // forwarding priority
        mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; mem_werf = 1'b1; wb_werf = 1'b1;
        #1 chk("fwd_mem_prio", 32'(fwd_a_sel), 32'd2);
        step();
        mem_rd = 5'd0;
        #1 chk("fwd_wb", 32'(fwd_a_sel), 32'd1);
        step();
        ex_rs1 = 5'd0; wb_rd = 5'd0;
        #1 chk("fwd_x0", 32'(fwd_a_sel), 32'd0);
        step();
        idle_inputs();

        // timeout: ready never arrives
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < MAXW + 3; i++) step();
        chk("fault_mem_err", 32'(mem_err), 32'd1);
        chk("fault_enables", 32'(ctrl_vec()), 32'd0);
        idle_inputs();
        step();
        chk("fault_sticky", 32'(mem_err), 32'd1);
        do_reset();
        chk("fault_cleared", 32'(mem_err), 32'd0);

        // reset in the middle of a memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        step(); step();
        do_reset();
        mem_req = 1'b0;
        step();
        chk("after_reset_enables", 32'(ctrl_vec()), 32'h1F0);

        // randomized traffic; an unfinished access keeps mem_req high until ready
        for (int n = 0; n < 600; n++) begin
            if (m_fault && $urandom_range(0, 2) == 0) do_reset();
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            ex_rs1 = 5'($urandom_range(0, 7));
            ex_rs2 = 5'($urandom_range(0, 7));
            ex_rd  = 5'($urandom_range(0, 7));
            mem_rd = 5'($urandom_range(0, 7));
            wb_rd  = 5'($urandom_range(0, 7));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_werf        = 1'($urandom_range(0, 1));
            wb_werf         = 1'($urandom_range(0, 1));
            if (!(mem_req && !mem_ready)) mem_req = ($urandom_range(0, 2) == 0);
            mem_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, the maximum number of data-memory wait cycles before a fault.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: id_rs1, id_rs2  in  5  source registers of the ID-stage instruction.
REQ-004 SHALL have ports: ex_rs1, ex_rs2  in  5  source registers of the EX-stage instruction; ex_rd  in  5  EX destination; ex_mem_read  in  1  EX instruction is a load.
REQ-005 SHALL have ports: ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-006 SHALL have ports: mem_rd  in  5; mem_werf  in  1  MEM-stage destination and write enable; mem_req  in  1  MEM instruction accesses data memory; mem_ready  in  1  data memory completes this cycle.
REQ-007 SHALL have ports: wb_rd  in  5; wb_werf  in  1  WB-stage destination and write enable.
REQ-008 SHALL have ports: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage-register load enables.
REQ-009 SHALL have ports: ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load a bubble (all-zero, werf=0).
REQ-010 SHALL have ports: fwd_a_sel, fwd_b_sel  out  2  EX operand source (00 regfile, 01 WB, 10 MEM).
REQ-011 SHALL have ports: mem_err  out  1  sticky memory-timeout fault; stall_cycles  out  32  saturating count of stalled cycles.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, FAULT.
REQ-013 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; MEM_WAIT -> RUN when mem_ready=1; MEM_WAIT -> FAULT when mem_ready=0 and wait_cnt=MAX_WAIT-1; FAULT is left only by reset.
REQ-014 SHALL clear wait_cnt on entry to MEM_WAIT and increment it each MEM_WAIT cycle with mem_ready=0.
REQ-015 Memory stall (RUN or MEM_WAIT with mem_req=1, mem_ready=0): pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1, memwb_flush=1; other flushes 0.
REQ-016 Branch (no memory stall, ex_branch_taken=1): all enables 1, ifid_flush=1, idex_flush=1.
REQ-017 Load-use (no memory stall, no branch, ex_mem_read=1, ex_rd!=0, ex_rd equals id_rs1 or id_rs2): pc_en=0, ifid_en=0, idex_flush=1, other enables 1.
REQ-018 Otherwise all enables 1, all flushes 0.
REQ-019 Priority SHALL be memory stall > branch > load-use; a branch coincident with load-use SHALL NOT stall.
REQ-020 The MEM_WAIT cycle with mem_ready=1 SHALL produce outputs per REQ-016..018 (zero extra latency on release).
REQ-021 FAULT: all enables 0, all flushes 0, mem_err=1.
REQ-022 Flush SHALL be asserted only together with its stage enable = 1.
REQ-023 fwd_a_sel=10 when mem_werf=1, mem_rd!=0, mem_rd=ex_rs1; else 01 when wb_werf=1, wb_rd!=0, wb_rd=ex_rs1; else 00; fwd_b_sel likewise with ex_rs2; purely combinational.
REQ-024 stall_cycles SHALL increment on each cycle with pc_en=0 outside FAULT, saturating at 0xFFFF_FFFF.
REQ-025 All stage-control outputs SHALL be combinational from state and inputs (no added latency).

Reset
REQ-026 While rst=0: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, all enables 0, all flushes 0, fwd selects 00.
REQ-027 Reset asserted mid-MEM_WAIT or in FAULT SHALL return immediately to RUN; first cycle after release follows REQ-015..018.

Structure
REQ-028 State encoding and forwarding-select constants (FWD_RF, FWD_WB, FWD_MEM) SHALL reside in the shared pipeline package.
REQ-029 Forwarding logic SHALL be a sub-module fwd_unit; hazard FSM and counters stay in pipeline_ctrl.

Verification
REQ-030 Load x5 in EX (ex_rd=5, ex_mem_read=1), id_rs2=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1.
REQ-031 Same as REQ-030 plus ex_branch_taken=1 -> pc_en=1, ifid_flush=1, idex_flush=1, no stall.
REQ-032 mem_req=1, mem_ready low 3 cycles then high -> 3 cycles frozen with memwb_flush=1, RUN on 4th, stall_cycles=3.
REQ-033 MAX_WAIT=4, mem_ready never high -> FAULT after 4 wait cycles, mem_err=1 sticky, all enables 0; rst low -> mem_err=0.
REQ-034 mem_rd=wb_rd=ex_rs1=7, both werf=1 -> fwd_a_sel=10; mem_rd=0 -> 01; ex_rs1=0 with wb_rd=0 -> 00.
REQ-035 rst low during MEM_WAIT -> all outputs per REQ-026 same cycle; release with mem_req=0 -> all enables 1.
